// File: rtl/bullet_engine_pkg.sv
// Shared constants and types for the bullet sequencer: play-area size,
// colour and edge codes, FSM states and a small distance helper.
package bullet_engine_pkg;

  localparam int unsigned AREA_MAX = 200;

  localparam logic [1:0] COL_WHITE = 2'd0;
  localparam logic [1:0] COL_GREEN = 2'd1;
  localparam logic [1:0] COL_BLUE  = 2'd2;

  localparam logic [1:0] EDGE_LEFT   = 2'd0;
  localparam logic [1:0] EDGE_RIGHT  = 2'd1;
  localparam logic [1:0] EDGE_TOP    = 2'd2;
  localparam logic [1:0] EDGE_BOTTOM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_MOVE,
    ST_COOL
  } state_e;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bullet_engine_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running while out of reset.
module lfsr16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift left, feedback from taps 16,14,13,11 enters at bit 0
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // State register, loads the seed on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= seed;
    else          lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/bullet_engine.sv
// Frame-synchronous bullet sequencer: spawns one bullet at a random edge,
// moves it per frame_tick, reports heart collisions as damage/heal pulses.
// Optional macro BULLET_ENGINE_SPEEDUP_EN: step grows by 1 every 8 despawns,
// saturating at 4*SPEED.
module bullet_engine
  import bullet_engine_pkg::*;
#(
  parameter int unsigned SPEED    = 2,
  parameter int unsigned HIT_R    = 12,
  parameter int unsigned BLUE_R   = 54,
  parameter int unsigned COOLDOWN = 30,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [15:0] player_pos,
  output logic [15:0] bullet_pos,
  output logic [1:0]  bullet_color,
  output logic        is_render,
  output logic        hit_dmg,
  output logic        hit_heal
);

  localparam int unsigned CNT_W = $clog2(COOLDOWN + 1);
  localparam logic [8:0]  AMAX9 = 9'(AREA_MAX);
  localparam logic [7:0]  AMAX8 = 8'(AREA_MAX);
  localparam logic [7:0]  WRAP8 = 8'(AREA_MAX + 1);
  localparam logic [7:0]  HIT8  = 8'(HIT_R);
  localparam logic [7:0]  BLUE8 = 8'(BLUE_R);
  localparam logic [7:0]  STEP0 = 8'(SPEED);

  state_e           state_q, state_d;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic [1:0]       col_q, col_d, dir_q, dir_d;
  logic             render_q, render_d, dmg_q, dmg_d, heal_q, heal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      prev_q, prev_d;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [7:0]  along, mv, dx, dy, radius, step;
  logic [8:0]  nxt;
  logic        inc, horiz, exit_w, hit, despawn;

  lfsr16 u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .seed   (SEED),
    .out    (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:12];

`ifdef BULLET_ENGINE_SPEEDUP_EN
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] step_q, step_d;
  localparam logic [7:0] STEP_MAX = 8'(4 * SPEED);

  assign step = step_q;

  // Despawn counter drives the step size; disabling the game restores base speed
  always_comb begin
    bcnt_d = bcnt_q;
    step_d = step_q;
    if (!enable) begin
      bcnt_d = '0;
      step_d = STEP0;
    end else if (despawn) begin
      bcnt_d = bcnt_q + 4'd1;
      if (bcnt_d[2:0] == 3'd0 && step_q < STEP_MAX) step_d = step_q + 8'd1;
    end
  end

  // Speed-up registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q <= '0;
      step_q <= STEP0;
    end else begin
      bcnt_q <= bcnt_d;
      step_q <= step_d;
    end
  end
`else
  assign step = STEP0;
`endif

  // Datapath: spawn coordinate, next step along the travel axis, collision test
  always_comb begin
    along  = (lfsr[9:2] > AMAX8) ? (lfsr[9:2] - WRAP8) : lfsr[9:2];
    horiz  = (dir_q == EDGE_LEFT) || (dir_q == EDGE_RIGHT);
    inc    = (dir_q == EDGE_LEFT) || (dir_q == EDGE_TOP);
    mv     = horiz ? x_q : y_q;
    if (inc) begin
      nxt    = {1'b0, mv} + {1'b0, step};
      exit_w = nxt > AMAX9;
    end else begin
      nxt    = {1'b0, mv} - {1'b0, step};
      exit_w = {1'b0, mv} < {1'b0, step};
    end
    dx     = abs_diff(x_q, player_pos[15:8]);
    dy     = abs_diff(y_q, player_pos[7:0]);
    radius = (col_q == COL_BLUE) ? BLUE8 : HIT8;
    hit    = (dx <= radius) && (dy <= radius) &&
             ((col_q != COL_BLUE) || (player_pos != prev_q));
  end

  // FSM next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    dir_d    = dir_q;
    render_d = render_q;
    dmg_d    = 1'b0;
    heal_d   = 1'b0;
    cnt_d    = cnt_q;
    prev_d   = frame_tick ? player_pos : prev_q;
    despawn  = 1'b0;
    if (!enable) begin
      state_d  = ST_IDLE;
      render_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          render_d = 1'b0;
          state_d  = ST_SPAWN;
        end
        ST_SPAWN: begin
          dir_d    = lfsr[1:0];
          col_d    = (lfsr[11:10] == 2'd3) ? COL_WHITE : lfsr[11:10];
          case (lfsr[1:0])
            EDGE_LEFT:  begin x_d = '0;    y_d = along; end
            EDGE_RIGHT: begin x_d = AMAX8; y_d = along; end
            EDGE_TOP:   begin x_d = along; y_d = '0;    end
            default:    begin x_d = along; y_d = AMAX8; end
          endcase
          render_d = 1'b1;
          state_d  = ST_MOVE;
        end
        ST_MOVE: begin
          if (frame_tick) begin
            // Collision uses the pre-step position and wins over an edge exit
            if (hit) begin
              dmg_d   = (col_q != COL_GREEN);
              heal_d  = (col_q == COL_GREEN);
              despawn = 1'b1;
            end else if (exit_w) begin
              despawn = 1'b1;
            end else if (horiz) begin
              x_d = nxt[7:0];
            end else begin
              y_d = nxt[7:0];
            end
            if (despawn) begin
              render_d = 1'b0;
              cnt_d    = CNT_W'(COOLDOWN);
              state_d  = ST_COOL;
            end
          end
        end
        default: begin
          if (cnt_q == '0)     state_d = ST_SPAWN;
          else if (frame_tick) cnt_d   = cnt_q - 1'b1;
        end
      endcase
    end
  end

  // All FSM state and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= COL_WHITE;
      dir_q    <= EDGE_LEFT;
      render_q <= 1'b0;
      dmg_q    <= 1'b0;
      heal_q   <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      dir_q    <= dir_d;
      render_q <= render_d;
      dmg_q    <= dmg_d;
      heal_q   <= heal_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
    end
  end

  assign bullet_pos   = {x_q, y_q};
  assign bullet_color = col_q;
  assign is_render    = render_q;
  assign hit_dmg      = dmg_q;
  assign hit_heal     = heal_q;

endmodule
